// File: rtl/kamacore_datatypes_pkg.sv
// Shared widths and state/owner types for the KamaCore memory arbiter.
package kamacore_datatypes;

  localparam int CPU_WIDTH = 32;
  localparam int BE_WIDTH  = CPU_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/kamacore_arb_picker.sv
// Owner selection between the fetch and data ports. With last_owner tied to
// OWNER_IF, contention always resolves to data.
module kamacore_arb_picker
  import kamacore_datatypes::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output arb_owner_t owner
);

  // Contention goes to the port that did not win last; a lone request wins outright.
  always_comb begin
    owner = OWNER_IF;
    if (if_req && d_req) begin
      owner = (last_owner == OWNER_D) ? OWNER_IF : OWNER_D;
    end else if (d_req) begin
      owner = OWNER_D;
    end else begin
      owner = OWNER_IF;
    end
  end

endmodule

// File: rtl/kamacore_mem_arbiter.sv
// Single-outstanding memory arbiter between fetch and data ports.
// Define KAMACORE_MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is data priority.
module kamacore_mem_arbiter
  import kamacore_datatypes::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [CPU_WIDTH-1:0]  if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [CPU_WIDTH-1:0]  d_wdata,
  input  logic [BE_WIDTH-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [CPU_WIDTH-1:0]  d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CPU_WIDTH-1:0]  mem_wdata,
  output logic [BE_WIDTH-1:0]   mem_be,
  input  logic                  mem_rvalid,
  input  logic [CPU_WIDTH-1:0]  mem_rdata,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state_r;
  arb_state_t       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  arb_owner_t       owner_s;
  arb_owner_t       last_owner_s;
  logic             grant_s;
  logic             expire_s;

  // Grants are gated by rst so a request held during reset never leaks out.
  assign grant_s  = rst && (state_r == IDLE) && (if_req || d_req);
  assign expire_s = (cnt_r == CNT_W'(TIMEOUT - 1));

`ifdef KAMACORE_MEM_ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner_r;

  // Remember who won the most recent grant for round-robin contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_r <= OWNER_IF;
    end else if (grant_s) begin
      last_owner_r <= owner_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  assign last_owner_s = last_owner_r;
`else
  assign last_owner_s = OWNER_IF;
`endif

  kamacore_arb_picker u_picker (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner_s),
    .owner      (owner_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // cnt_r holds the number of WAIT cycles already completed; it restarts in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == IDLE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Next state, grant, memory payload and response routing.
  always_comb begin
    next_state_s = state_r;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    d_rvalid     = 1'b0;
    if_rdata     = {CPU_WIDTH{1'b0}};
    d_rdata      = {CPU_WIDTH{1'b0}};
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {ADDR_WIDTH{1'b0}};
    mem_wdata    = {CPU_WIDTH{1'b0}};
    mem_be       = {BE_WIDTH{1'b0}};
    busy         = 1'b0;
    timeout_err  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s && (owner_s == OWNER_D)) begin
          d_gnt        = 1'b1;
          mem_req      = 1'b1;
          mem_we       = d_we;
          mem_addr     = d_addr;
          mem_wdata    = d_wdata;
          mem_be       = d_be;
          next_state_s = WAIT_D;
        end else if (grant_s) begin
          if_gnt       = 1'b1;
          mem_req      = 1'b1;
          mem_addr     = if_addr;
          mem_be       = {BE_WIDTH{1'b1}};
          next_state_s = WAIT_IF;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_IF, WAIT_D: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          if (state_r == WAIT_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end
          next_state_s = IDLE;
        end else if (expire_s) begin
          timeout_err  = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule
